// File: rtl/div8_seq_pkg.sv
// Shared widths and FSM encoding for the sequential 8-bit divider.
// Used by div8_seq and its testbench; no logic lives here.
package div8_pkg;

    localparam int DIV8_W    = 8;
    localparam int DIV8_ITER = 8;

    typedef logic [1:0] div8_state_t;

    localparam div8_state_t ST_IDLE = 2'd0;
    localparam div8_state_t ST_RUN  = 2'd1;
    localparam div8_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/div8_seq_sum8b.sv
// 8-bit add/subtract unit: sel=1 gives a-b with cout=1 meaning no borrow, sel=0 gives a+b.
// Latency: combinational, zero cycles.
// Backpressure: none, purely combinational.
module sum8b (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sel,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] b_eff;

    // Two's-complement subtract: invert b and inject the carry-in.
    assign b_eff       = sel ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {8'd0, sel};

endmodule

// File: rtl/div8_seq.sv
// Sequential 8-bit unsigned restoring divider sharing one sum8b over eight iterations.
// Latency: start to done is 9 cycles (1 cycle for a zero divisor when DIV8_ZERO_CHECK_EN is defined).
// Backpressure: start is accepted only in IDLE; start while busy is dropped, no queueing.
module div8_seq
    import div8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIV8_W-1:0] dividend,
    input  logic [DIV8_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DIV8_W-1:0] quotient,
    output logic [DIV8_W-1:0] remainder,
    output logic              div_zero
);

    localparam int CNT_W = $clog2(DIV8_ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV8_ITER - 1);

    div8_state_t       state;
    logic [DIV8_W-1:0] part_rem;
    logic [DIV8_W-1:0] quo_sh;
    logic [DIV8_W-1:0] dvs;
    logic [CNT_W-1:0]  cnt;

    logic [DIV8_W-1:0] trial;
    logic [DIV8_W-1:0] diff;
    logic              no_borrow;
    logic [DIV8_W-1:0] next_rem;
    logic [DIV8_W-1:0] next_quo;
    logic              accept;
    logic              skip_run;

    // The partial remainder stays below 2^k after k steps, so dropping R[7] loses nothing.
    assign trial = {part_rem[DIV8_W-2:0], quo_sh[DIV8_W-1]};

    sum8b u_sum8b (
        .a    (trial),
        .b    (dvs),
        .sel  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    assign next_rem = no_borrow ? diff : trial;
    assign next_quo = {quo_sh[DIV8_W-2:0], no_borrow};

    assign accept = (state == ST_IDLE) && start;
    assign busy   = (state == ST_RUN) || (state == ST_DONE);
    assign done   = (state == ST_DONE);

`ifdef DIV8_ZERO_CHECK_EN
    logic zero_flag;

    assign skip_run = (divisor == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_flag <= 1'b0;
        end else if (accept) begin
            zero_flag <= skip_run;
        end
    end

    assign div_zero = zero_flag;
`else
    assign skip_run = 1'b0;
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            part_rem  <= '0;
            quo_sh    <= '0;
            dvs       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        part_rem <= '0;
                        quo_sh   <= dividend;
                        dvs      <= divisor;
                        cnt      <= '0;
                        if (skip_run) begin
                            // Same result values the full iteration would give for a zero divisor.
                            quotient  <= '1;
                            remainder <= dividend;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    part_rem <= next_rem;
                    quo_sh   <= next_quo;
                    cnt      <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        quotient  <= next_quo;
                        remainder <= next_rem;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div8_seq.sv
// Directed testbench for div8_seq with a result scoreboard and immediate-assertion checks.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_div8_seq;
    import div8_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    div8_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int dvd, input int dvs);
        exp_t e;
        if (dvs == 0) begin
            e.q = 8'hFF;
            e.r = 8'(dvd);
`ifdef DIV8_ZERO_CHECK_EN
            e.z   = 1'b1;
            e.lat = 1;
`else
            e.z   = 1'b0;
            e.lat = DIV8_ITER + 1;
`endif
        end else begin
            e.q   = 8'(dvd / dvs);
            e.r   = 8'(dvd % dvs);
            e.z   = 1'b0;
            e.lat = DIV8_ITER + 1;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // One division from a single start pulse; glitch re-pulses start mid-run with other operands.
    task automatic run_div(input string tag, input int dvd, input int dvs, input bit glitch);
        exp_t e;
        int   cyc;
        int   busy_cnt;
        bit   got;
        @(negedge clk);
        dividend = 8'(dvd);
        divisor  = 8'(dvs);
        start    = 1'b1;
        sb.push_back(model(dvd, dvs));
        cyc      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
            if (done) got = 1'b1;
            start = glitch && (cyc == 2 || cyc == 4);
            if (start) begin
                dividend = 8'd200;
                divisor  = 8'd3;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        e = sb.pop_front();
        check({tag, "_quotient"}, 32'(quotient), 32'(e.q));
        check({tag, "_remainder"}, 32'(remainder), 32'(e.r));
        check({tag, "_div_zero"}, 32'(div_zero), 32'(e.z));
        check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_quotient_held"}, 32'(quotient), 32'(e.q));
        check({tag, "_remainder_held"}, 32'(remainder), 32'(e.r));
    endtask

    task automatic count_stray_done(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        check(tag, 32'(n), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   cyc;
        int   last;
        int   n;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_div_zero", 32'(div_zero), 32'd0);
        rst = 1'b0;

        run_div("d200_10", 200, 10, 1'b0);
        run_div("d255_1", 255, 1, 1'b0);
        run_div("d7_9", 7, 9, 1'b0);
        run_div("d255_255", 255, 255, 1'b0);
        run_div("d100_0", 100, 0, 1'b0);

        run_div("ignored_start", 50, 7, 1'b1);
        count_stray_done("ignored_start_no_extra_done", 12);

        // Abort in the fourth RUN cycle.
        @(negedge clk);
        dividend = 8'd77;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        count_stray_done("abort_no_done", 12);
        run_div("d81_9", 81, 9, 1'b0);

        // start held high: back-to-back divisions.
        @(negedge clk);
        dividend = 8'd123;
        divisor  = 8'd10;
        start    = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back(model(123, 10));
        cyc  = 0;
        last = 0;
        n    = 0;
        while (n < 3 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                e = sb.pop_front();
                check("b2b_quotient", 32'(quotient), 32'(e.q));
                check("b2b_remainder", 32'(remainder), 32'(e.r));
                if (n == 0) check("b2b_first_latency", 32'(cyc), 32'(e.lat));
                else        check("b2b_gap", 32'(cyc - last), 32'(DIV8_ITER + 2));
                last = cyc;
                n++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 32'(n), 32'd3);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
